sdram_wr_scheduler: RTL and testbench

// - Sequences the stream path from generator FIFO into SDRAM at CLK48M: gates the generator, issues write bursts, schedules refresh.
// - Sits between fifo_to_sdram (usedw/rdreq), stream_generator (enable) and SDRAM_controller (burst/refresh handshakes).
// - Owns the SDRAM write pointer and the start/stop command coming from the FTDI command FSM.

---
 rtl/sdram_wr_scheduler_if.sv | 22 ++
 rtl/sdram_wr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sdram_wr_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_scheduler_if.sv
// rtl/sdram_wr_scheduler_if.sv - burst/refresh handshake and FIFO read strobe between scheduler and SDRAM controller
interface sdram_wr_scheduler_if #(
  parameter int ADDR_W = 24
);
  logic              ctrl_idle;
  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_ack;
  logic              fifo_rdreq;
  logic              refresh_req;
  logic              refresh_ack;

  modport master (
    output burst_req, burst_addr, fifo_rdreq, refresh_req,
    input  ctrl_idle, burst_ack, refresh_ack
  );

  modport slave (
    input  burst_req, burst_addr, fifo_rdreq, refresh_req,
    output ctrl_idle, burst_ack, refresh_ack
  );
endinterface

// File: rtl/sdram_wr_scheduler.sv
// rtl/sdram_wr_scheduler.sv - gates the stream generator, issues SDRAM write bursts and schedules refresh
// Define SDRAM_SCHED_WRAP_EN to let the write pointer wrap; otherwise the region stops at the top (mem_full).
module sdram_wr_scheduler #(
  parameter int BURST_LEN      = 256,
  parameter int ADDR_W         = 24,
  parameter int REFRESH_PERIOD = 374,
  parameter int FIFO_HI        = 768
) (
  input  logic                 CLK48M,
  input  logic                 RESET,
  input  logic                 start_async_i,
  input  logic [9:0]           usedw_i,
  input  logic                 fifo_full_i,
  sdram_wr_scheduler_if.master ctrl,
  output logic                 gen_enable_o,
  output logic                 mem_full_o,
  output logic                 overflow_o,
  output logic [15:0]          bursts_done_o
);

  localparam int                BEAT_W      = $clog2(BURST_LEN);
  localparam int                REF_W       = $clog2(REFRESH_PERIOD);
  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
  localparam logic [REF_W-1:0]  REF_LAST    = REF_W'(REFRESH_PERIOD - 1);
  localparam logic [9:0]        BURST_THR   = 10'(BURST_LEN);
  localparam logic [9:0]        FIFO_HI_THR = 10'(FIFO_HI);
  localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_BURST,
    S_REFRESH
  } state_t;

  state_t            state_q, state_d;
  logic              start_meta_q;
  logic              run_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       done_q, done_d;
  logic              mem_full_q, mem_full_d;
  logic              overflow_q, overflow_d;
  logic              gen_en_q, gen_en_d;

  logic              ref_expire;
  logic              burst_end;
  logic [ADDR_W-1:0] addr_next;

  // State register plus datapath registers; async reset drops all requests at once.
  always_ff @(posedge CLK48M or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      start_meta_q <= 1'b0;
      run_q        <= 1'b0;
      beat_q       <= '0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      addr_q       <= '0;
      done_q       <= '0;
      mem_full_q   <= 1'b0;
      overflow_q   <= 1'b0;
      gen_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_meta_q <= start_async_i;
      run_q        <= start_meta_q;
      beat_q       <= beat_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      mem_full_q   <= mem_full_d;
      overflow_q   <= overflow_d;
      gen_en_q     <= gen_en_d;
    end
  end

  // Next-state logic: a pending refresh wins over a new burst, never over one in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else if (ref_pend_q && ctrl.ctrl_idle) begin
          state_d = S_REFRESH;
        end else if ((usedw_i >= BURST_THR) && ctrl.ctrl_idle && !mem_full_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ctrl.burst_ack) state_d = S_BURST;
      end
      S_BURST: begin
        if (beat_q == BEAT_LAST) state_d = S_ARM;
      end
      S_REFRESH: begin
        if (ctrl.refresh_ack) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ref_expire = (ref_cnt_q == REF_LAST);
  assign ref_cnt_d  = ref_expire ? '0 : ref_cnt_q + 1'b1;
  assign ref_pend_d = ref_expire | (ref_pend_q & ~((state_q == S_REFRESH) & ctrl.refresh_ack));

  assign burst_end  = (state_q == S_BURST) && (beat_q == BEAT_LAST);
  assign addr_next  = addr_q + ADDR_STEP;

  always_comb begin
    beat_d     = (state_q == S_BURST) ? beat_q + 1'b1 : '0;
    addr_d     = addr_q;
    done_d     = done_q;
    mem_full_d = mem_full_q;
    if (burst_end) begin
      done_d = done_q + 16'd1;
`ifdef SDRAM_SCHED_WRAP_EN
      addr_d = addr_next;
`else
      // Stop at the top of the region instead of overwriting address 0.
      if (addr_next == '0) begin
        mem_full_d = 1'b1;
      end else begin
        addr_d = addr_next;
      end
`endif
    end
  end

  assign gen_en_d   = run_q & (state_q != S_IDLE) & (usedw_i < FIFO_HI_THR) & ~mem_full_q;
  assign overflow_d = overflow_q | (fifo_full_i & run_q);

  // Output logic: handshake strobes decode directly from the state register.
  always_comb begin
    ctrl.burst_req   = 1'b0;
    ctrl.fifo_rdreq  = 1'b0;
    ctrl.refresh_req = 1'b0;
    case (state_q)
      S_REQ:     ctrl.burst_req   = 1'b1;
      S_BURST:   ctrl.fifo_rdreq  = 1'b1;
      S_REFRESH: ctrl.refresh_req = 1'b1;
      default: ;
    endcase
  end

  assign ctrl.burst_addr   = addr_q;
  assign gen_enable_o      = gen_en_q;
  assign mem_full_o        = mem_full_q;
  assign overflow_o        = overflow_q;
  assign bursts_done_o     = done_q;

endmodule

// File: tb/tb_sdram_wr_scheduler.sv
// tb/tb_sdram_wr_scheduler.sv - directed bench for sdram_wr_scheduler (ADDR_W=10 so the region fills in 4 bursts)
module tb_sdram_wr_scheduler;

  localparam int AW = 10;

  logic        CLK48M = 1'b0;
  logic        RESET;
  logic        start_async;
  logic [9:0]  usedw;
  logic        fifo_full;
  logic        gen_enable;
  logic        mem_full;
  logic        overflow;
  logic [15:0] bursts_done;

  int checks = 0;
  int passed = 0;

  sdram_wr_scheduler_if #(.ADDR_W(AW)) bus ();

  sdram_wr_scheduler #(
    .BURST_LEN(256), .ADDR_W(AW), .REFRESH_PERIOD(374), .FIFO_HI(768)
  ) dut (
    .CLK48M(CLK48M), .RESET(RESET), .start_async_i(start_async), .usedw_i(usedw),
    .fifo_full_i(fifo_full), .ctrl(bus), .gen_enable_o(gen_enable), .mem_full_o(mem_full),
    .overflow_o(overflow), .bursts_done_o(bursts_done)
  );

  always #10 CLK48M = ~CLK48M;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Controller model: acks refresh immediately, returns cycles until burst_req (-1 on timeout).
  task automatic wait_burst(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK48M);
      bus.refresh_ack = bus.refresh_req;
      if (bus.burst_req) begin
        cyc = i;
        break;
      end
    end
    bus.refresh_ack = 1'b0;
  endtask

  // Acks the pending burst and counts consecutive fifo_rdreq cycles; drops start at beat stop_at.
  task automatic run_burst(input int stop_at, output int n);
    bus.burst_ack = 1'b1;
    @(negedge CLK48M);
    bus.burst_ack = 1'b0;
    n = 0;
    while (bus.fifo_rdreq && n < 600) begin
      n++;
      if (n == stop_at) start_async = 1'b0;
      @(negedge CLK48M);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0; start_async = 1'b0; usedw = '0; fifo_full = 1'b0;
    bus.ctrl_idle = 1'b1; bus.burst_ack = 1'b0; bus.refresh_ack = 1'b0;
    repeat (3) @(negedge CLK48M);
    checks++; if (bus.burst_req !== 1'b0) $display("FAIL reset_burst_req: got %b expected 0", bus.burst_req); else passed++;
    checks++; if (bus.fifo_rdreq !== 1'b0) $display("FAIL reset_rdreq: got %b expected 0", bus.fifo_rdreq); else passed++;
    checks++; if (bus.refresh_req !== 1'b0) $display("FAIL reset_refresh_req: got %b expected 0", bus.refresh_req); else passed++;
    checks++; if (bus.burst_addr !== 10'h000) $display("FAIL reset_addr: got %h expected 000", bus.burst_addr); else passed++;
    checks++; if (gen_enable !== 1'b0) $display("FAIL reset_gen_enable: got %b expected 0", gen_enable); else passed++;
    checks++; if (mem_full !== 1'b0) $display("FAIL reset_mem_full: got %b expected 0", mem_full); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    checks++; if (bursts_done !== 16'd0) $display("FAIL reset_bursts_done: got %0d expected 0", bursts_done); else passed++;
    RESET = 1'b1;
    fifo_full = 1'b1;
    @(negedge CLK48M);
    fifo_full = 1'b0;
    @(negedge CLK48M);
    checks++; if (overflow !== 1'b0) $display("FAIL overflow_while_stopped: got %b expected 0", overflow); else passed++;
  endtask

  task automatic test_first_burst;
    int cyc, n;
    usedw = 10'd300;
    start_async = 1'b1;
    wait_burst(10, cyc);
    checks++; if (!(cyc >= 1 && cyc <= 4)) $display("FAIL first_req_latency: got %0d cycles expected 1..4", cyc); else passed++;
    checks++; if (bus.burst_addr !== 10'h000) $display("FAIL first_addr: got %h expected 000", bus.burst_addr); else passed++;
    checks++; if (gen_enable !== 1'b1) $display("FAIL first_gen_enable: got %b expected 1", gen_enable); else passed++;
    run_burst(0, n);
    usedw = 10'd255;
    checks++; if (n !== 256) $display("FAIL first_rdreq_len: got %0d expected 256", n); else passed++;
    checks++; if (bus.burst_addr !== 10'h100) $display("FAIL first_addr_after: got %h expected 100", bus.burst_addr); else passed++;
    checks++; if (bursts_done !== 16'd1) $display("FAIL first_bursts_done: got %0d expected 1", bursts_done); else passed++;
  endtask

  task automatic test_refresh_only;
    int rise [2];
    int nrise;
    bit prev, saw_burst, gen_low;
    bus.burst_ack = 1'b1;
    @(negedge CLK48M);
    bus.burst_ack = 1'b0;
    checks++; if (bus.fifo_rdreq !== 1'b0) $display("FAIL stray_ack_rdreq: got %b expected 0", bus.fifo_rdreq); else passed++;
    nrise = 0; prev = 1'b0; saw_burst = 1'b0; gen_low = 1'b0; rise[0] = 0; rise[1] = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge CLK48M);
      if (bus.refresh_req && !prev) begin
        if (nrise < 2) rise[nrise] = i;
        nrise++;
      end
      prev = bus.refresh_req;
      bus.refresh_ack = bus.refresh_req;
      if (bus.burst_req) saw_burst = 1'b1;
      if (!gen_enable) gen_low = 1'b1;
    end
    checks++; if (nrise < 2) $display("FAIL refresh_count: got %0d expected >=2", nrise); else passed++;
    checks++; if (rise[1] - rise[0] !== 374) $display("FAIL refresh_period: got %0d expected 374", rise[1] - rise[0]); else passed++;
    checks++; if (saw_burst !== 1'b0) $display("FAIL below_threshold_burst: got %b expected 0", saw_burst); else passed++;
    checks++; if (gen_low !== 1'b0) $display("FAIL refresh_gen_enable_low: got %b expected 0", gen_low); else passed++;
  endtask

  task automatic test_refresh_priority;
    int cyc, n;
    bus.ctrl_idle = 1'b0;
    usedw = 10'd800;
    repeat (2) begin
      @(negedge CLK48M);
      bus.refresh_ack = bus.refresh_req;
    end
    checks++; if (gen_enable !== 1'b0) $display("FAIL fifo_hi_gen_enable: got %b expected 0", gen_enable); else passed++;
    usedw = 10'd512;
    repeat (400) begin
      @(negedge CLK48M);
      bus.refresh_ack = bus.refresh_req;
    end
    bus.refresh_ack = 1'b0;
    bus.ctrl_idle = 1'b1;
    @(negedge CLK48M);
    checks++; if (bus.refresh_req !== 1'b1) $display("FAIL prio_refresh_first: got %b expected 1", bus.refresh_req); else passed++;
    checks++; if (bus.burst_req !== 1'b0) $display("FAIL prio_no_burst: got %b expected 0", bus.burst_req); else passed++;
    repeat (3) @(negedge CLK48M);
    checks++; if (bus.burst_req !== 1'b0) $display("FAIL prio_burst_held_off: got %b expected 0", bus.burst_req); else passed++;
    bus.refresh_ack = 1'b1;
    @(negedge CLK48M);
    bus.refresh_ack = 1'b0;
    checks++; if (bus.refresh_req !== 1'b0) $display("FAIL prio_refresh_released: got %b expected 0", bus.refresh_req); else passed++;
    wait_burst(10, cyc);
    checks++; if (cyc < 0) $display("FAIL prio_burst_after_ack: got timeout expected burst_req"); else passed++;
    run_burst(0, n);
    checks++; if (bus.burst_addr !== 10'h200) $display("FAIL prio_addr_after: got %h expected 200", bus.burst_addr); else passed++;
    checks++; if (bursts_done !== 16'd2) $display("FAIL prio_bursts_done: got %0d expected 2", bursts_done); else passed++;
  endtask

  task automatic test_stop_mid_burst;
    int cyc, n;
    bit saw_burst;
    wait_burst(20, cyc);
    checks++; if (bus.burst_addr !== 10'h200 || cyc < 0) $display("FAIL stop_req_addr: got %h (cyc %0d) expected 200", bus.burst_addr, cyc); else passed++;
    run_burst(100, n);
    checks++; if (n !== 256) $display("FAIL stop_rdreq_len: got %0d expected 256", n); else passed++;
    repeat (3) @(negedge CLK48M);
    checks++; if (gen_enable !== 1'b0) $display("FAIL stop_gen_enable: got %b expected 0", gen_enable); else passed++;
    saw_burst = 1'b0;
    repeat (20) begin
      @(negedge CLK48M);
      if (bus.burst_req || bus.refresh_req) saw_burst = 1'b1;
    end
    checks++; if (saw_burst !== 1'b0) $display("FAIL stop_idle_requests: got %b expected 0", saw_burst); else passed++;
    checks++; if (bus.burst_addr !== 10'h300) $display("FAIL stop_addr_kept: got %h expected 300", bus.burst_addr); else passed++;
    checks++; if (bursts_done !== 16'd3) $display("FAIL stop_bursts_done: got %0d expected 3", bursts_done); else passed++;
  endtask

  task automatic test_mem_full;
    int cyc, n;
    start_async = 1'b1;
    wait_burst(30, cyc);
    checks++; if (bus.burst_addr !== 10'h300 || cyc < 0) $display("FAIL resume_addr: got %h (cyc %0d) expected 300", bus.burst_addr, cyc); else passed++;
    run_burst(0, n);
    checks++; if (bursts_done !== 16'd4) $display("FAIL top_bursts_done: got %0d expected 4", bursts_done); else passed++;
`ifdef SDRAM_SCHED_WRAP_EN
    checks++; if (mem_full !== 1'b0) $display("FAIL wrap_mem_full: got %b expected 0", mem_full); else passed++;
    wait_burst(30, cyc);
    checks++; if (bus.burst_addr !== 10'h000 || cyc < 0) $display("FAIL wrap_fifth_addr: got %h (cyc %0d) expected 000", bus.burst_addr, cyc); else passed++;
`else
    checks++; if (mem_full !== 1'b1) $display("FAIL top_mem_full: got %b expected 1", mem_full); else passed++;
    checks++; if (bus.burst_addr !== 10'h300) $display("FAIL top_addr_held: got %h expected 300", bus.burst_addr); else passed++;
    wait_burst(50, cyc);
    checks++; if (cyc !== -1) $display("FAIL top_no_more_bursts: got burst_req at %0d expected none", cyc); else passed++;
    checks++; if (gen_enable !== 1'b0) $display("FAIL top_gen_enable: got %b expected 0", gen_enable); else passed++;
`endif
  endtask

  task automatic test_overflow;
    fifo_full = 1'b1;
    @(negedge CLK48M);
    fifo_full = 1'b0;
    @(negedge CLK48M);
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_set: got %b expected 1", overflow); else passed++;
    start_async = 1'b0;
    repeat (10) @(negedge CLK48M);
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", overflow); else passed++;
  endtask

  task automatic test_async_reset;
    int cyc;
    RESET = 1'b0;
    @(negedge CLK48M);
    checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow_clear: got %b expected 0", overflow); else passed++;
    checks++; if (mem_full !== 1'b0 || bursts_done !== 16'd0 || bus.burst_addr !== 10'h000)
      $display("FAIL rst_state_clear: got mem_full %b done %0d addr %h expected 0 0 000", mem_full, bursts_done, bus.burst_addr);
    else passed++;
    RESET = 1'b1;
    usedw = 10'd300;
    start_async = 1'b1;
    wait_burst(10, cyc);
    bus.burst_ack = 1'b1;
    @(negedge CLK48M);
    bus.burst_ack = 1'b0;
    repeat (9) @(negedge CLK48M);
    checks++; if (bus.fifo_rdreq !== 1'b1) $display("FAIL midburst_rdreq: got %b expected 1", bus.fifo_rdreq); else passed++;
    #3;
    RESET = 1'b0;
    #1;
    checks++; if (bus.fifo_rdreq !== 1'b0 || bus.burst_req !== 1'b0 || bus.refresh_req !== 1'b0)
      $display("FAIL async_reset_drop: got rdreq %b breq %b rreq %b expected 0 0 0", bus.fifo_rdreq, bus.burst_req, bus.refresh_req);
    else passed++;
    @(negedge CLK48M);
    RESET = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_refresh_only();
    test_refresh_priority();
    test_stop_mid_burst();
    test_mem_full();
    test_overflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
